// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_pkg;

    // Width of the requester id carried in the header low nibble.
    localparam int HDR_ID_W = 4;
    // Largest number of requesters the header format can address.
    localparam int MAX_SRC  = 16;

    // HDR_WAIT is reserved: the header loads straight into the output
    // register, so the FSM never visits it.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HDR_WAIT = 2'd1,
        PAYLOAD  = 2'd2
    } state_t;

    // Header byte for a given requester; base low nibble is expected to be 0.
    function automatic logic [7:0] hdr_byte(input logic [7:0] base,
                                            input logic [HDR_ID_W-1:0] id);
        return base | {4'h0, id};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the requester closest to ptr (going up,
// wrapping modulo N) wins.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]          req,
    input  logic [HDR_ID_W-1:0]   ptr,
    output logic [HDR_ID_W-1:0]   gnt_id,
    output logic                  any
);

    // Rotate-and-priority-encode expressed as "smallest forward distance
    // from ptr among the active requests".
    always_comb begin
        int            best_d;
        int            d;
        logic [N-1:0]  sh;
        gnt_id = '0;
        any    = 1'b0;
        best_d = N;
        d      = 0;
        sh     = '0;
        for (int j = 0; j < N; j++) begin
            sh = req >> j;
            d  = j - int'(ptr);
            if (d < 0) begin
                d = d + N;
            end
            if (sh[0] && (d < best_d)) begin
                best_d = d;
                gnt_id = HDR_ID_W'(j);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-level round-robin arbiter in front of the uart byte input.
// Each granted packet is prefixed by a one-byte source header and then
// forwarded unbroken until tlast.
//
// Handshake: every stream port transfers a byte on a rising edge where
// valid and ready are both high; valid never waits on ready, and the
// requester ready here never looks at that requester's own valid.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int         N_SRC    = 4,
    parameter logic [7:0] HDR_BASE = 8'hA0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_SRC*8-1:0]    s_axis_tdata,
    input  logic [N_SRC-1:0]      s_axis_tvalid,
    input  logic [N_SRC-1:0]      s_axis_tlast,
    output logic [N_SRC-1:0]      s_axis_tready,
    output logic [7:0]            m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic [HDR_ID_W-1:0]   grant_id
);

    state_t                state;
    logic [HDR_ID_W-1:0]   rr;
    logic [HDR_ID_W-1:0]   arb_id;
    logic                  arb_any;
    logic                  load_en;
    logic [7:0]            g_data;
    logic                  g_valid;
    logic                  g_last;
    logic                  xfer;
    logic [HDR_ID_W-1:0]   rr_next;

    // Output register may take a new byte when empty or being drained.
    assign load_en = !m_axis_tvalid || m_axis_tready;

    rr_arbiter #(.N(N_SRC)) u_arb (
        .req    (s_axis_tvalid),
        .ptr    (rr),
        .gnt_id (arb_id),
        .any    (arb_any)
    );

    // Select the granted requester's lane and drive its ready only.
    always_comb begin
        g_data        = '0;
        g_valid       = 1'b0;
        g_last        = 1'b0;
        s_axis_tready = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant_id == HDR_ID_W'(i)) begin
                g_data  = s_axis_tdata[i*8 +: 8];
                g_valid = s_axis_tvalid[i];
                g_last  = s_axis_tlast[i];
                if (state == PAYLOAD) begin
                    s_axis_tready[i] = load_en;
                end
            end
        end
    end

    assign xfer    = (state == PAYLOAD) && g_valid && load_en;
    assign rr_next = (grant_id == HDR_ID_W'(N_SRC - 1)) ? '0 : grant_id + 1'b1;
    assign busy    = (state != IDLE);

    // Grant FSM, output register, round-robin pointer and granted id.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rr            <= '0;
            grant_id      <= '0;
            m_axis_tdata  <= 8'h00;
            m_axis_tvalid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any && load_en) begin
                        grant_id      <= arb_id;
                        m_axis_tdata  <= hdr_byte(HDR_BASE, arb_id);
                        m_axis_tvalid <= 1'b1;
                        state         <= PAYLOAD;
                    end else if (load_en) begin
                        m_axis_tvalid <= 1'b0;
                    end
                end
                PAYLOAD: begin
                    if (xfer) begin
                        m_axis_tdata  <= g_data;
                        m_axis_tvalid <= 1'b1;
                        if (g_last) begin
                            state <= IDLE;
                            rr    <= rr_next;
                        end
                    end else if (load_en) begin
                        m_axis_tvalid <= 1'b0;
                    end
                end
                default: begin
                    if (load_en) begin
                        m_axis_tvalid <= 1'b0;
                    end
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: packet drivers per requester, a packet-level
// round-robin model that fills the expected queue, and a monitor that
// pops and compares every accepted output byte.
module tb_uart_tx_arb;

    localparam int N = 4;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic [N*8-1:0] s_tdata;
    logic [N-1:0]   s_tvalid;
    logic [N-1:0]   s_tlast;
    logic [N-1:0]   s_tready;
    logic [7:0]     m_tdata;
    logic           m_tvalid;
    logic           m_tready;
    logic           busy;
    logic [3:0]     grant_id;

    logic           src_valid [N];
    logic [7:0]     src_data  [N];
    logic           src_last  [N];

    for (genvar g = 0; g < N; g++) begin : g_map
        assign s_tdata[g*8 +: 8] = src_data[g];
        assign s_tvalid[g]       = src_valid[g];
        assign s_tlast[g]        = src_last[g];
    end

    uart_tx_arb #(.N_SRC(N), .HDR_BASE(8'hA0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .busy          (busy),
        .grant_id      (grant_id)
    );

    // ---------------- stimulus storage ----------------
    logic [7:0] pdata [N][8][6];
    int         plen  [N][8];
    int         pgap  [N][8][6];
    int         npkt  [N];

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    int  n_cmp      = 0;
    int  n_err      = 0;
    int  out_cnt    = 0;
    int  active_drv = 0;
    int  rdy_mode   = 0;
    int  bp_at      = -1;
    int  bp_hold    = 0;
    bit  abort      = 1'b0;
    bit  nogap      = 1'b0;
    bit  seen       = 1'b0;
    int  m_rr       = 0;
    int  m_gid      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Every requester with packets left keeps a first byte presented, so
    // each arbitration picks the first pending requester from the pointer.
    task automatic build_expected();
        int pi [N];
        int s;
        bit found;
        for (int i = 0; i < N; i++) pi[i] = 0;
        while (1) begin
            found = 1'b0;
            s = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && pi[(m_rr + k) % N] < npkt[(m_rr + k) % N]) begin
                    s = (m_rr + k) % N;
                    found = 1'b1;
                end
            end
            if (!found) break;
            exp_q.push_back(8'hA0 + 8'(s));
            for (int b = 0; b < plen[s][pi[s]]; b++) exp_q.push_back(pdata[s][pi[s]][b]);
            pi[s]++;
            m_rr  = (s + 1) % N;
            m_gid = s;
        end
    endtask

    task automatic clear_pkts();
        for (int s = 0; s < N; s++) npkt[s] = 0;
    endtask

    task automatic add_pkt(input int s, input int len, input int gapmax);
        int p;
        p = npkt[s];
        plen[s][p] = len;
        for (int b = 0; b < len; b++) begin
            pdata[s][p][b] = 8'($urandom_range(0, 255));
            pgap[s][p][b]  = (b == 0) ? 0 : $urandom_range(0, gapmax);
        end
        npkt[s] = p + 1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_src(input int s);
        bit hs;
        for (int p = 0; p < npkt[s] && !abort; p++) begin
            for (int b = 0; b < plen[s][p] && !abort; b++) begin
                repeat (pgap[s][p][b]) @(negedge clk);
                src_valid[s] = 1'b1;
                src_data[s]  = pdata[s][p][b];
                src_last[s]  = (b == plen[s][p] - 1);
                hs = 1'b0;
                while (!hs && !abort) begin
                    #4;
                    hs = s_tready[s];
                    @(negedge clk);
                end
                src_valid[s] = 1'b0;
            end
        end
        src_valid[s] = 1'b0;
        active_drv--;
    endtask

    task automatic start_drivers();
        for (int s = 0; s < N; s++) begin
            if (npkt[s] > 0) begin
                automatic int id = s;
                active_drv++;
                fork
                    drive_src(id);
                join_none
            end
        end
    endtask

    task automatic run_phase(input string name, input bit ng, input int mode);
        bit done;
        nogap    = ng;
        seen     = 1'b0;
        rdy_mode = mode;
        out_cnt  = 0;
        build_expected();
        start_drivers();
        done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            if (exp_q.size() == 0 && active_drv == 0) done = 1'b1;
            else @(negedge clk);
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: %0d bytes still expected", name, exp_q.size());
            abort = 1'b1;
            for (int c = 0; c < 50 && active_drv != 0; c++) @(negedge clk);
            exp_q.delete();
            abort = 1'b0;
        end
        bp_at = -1;
        repeat (2) @(negedge clk);
        chk({name, "_busy_idle"}, 32'(busy), 32'd0);
        chk({name, "_grant_id"}, 32'(grant_id), 32'(m_gid));
    endtask

    // ---------------- sink ready generator ----------------
    initial begin
        m_tready = 1'b1;
        forever begin
            @(negedge clk);
            if (bp_at >= 0 && out_cnt >= bp_at) begin
                bp_hold = 5;
                bp_at   = -1;
            end
            if (bp_hold > 0) begin
                m_tready = 1'b0;
                bp_hold--;
            end else if (rdy_mode == 1) begin
                m_tready = ($urandom_range(0, 3) != 0);
            end else begin
                m_tready = 1'b1;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        bit         hold_prev;
        logic [7:0] prev_data;
        logic [7:0] e;
        hold_prev = 1'b0;
        prev_data = 8'h00;
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    chk("hold_data", 32'(m_tdata), 32'(prev_data));
                    chk("hold_valid", 32'(m_tvalid), 32'd1);
                end
                if (s_tready != '0) chk("ready_onehot", 32'($onehot(s_tready)), 32'd1);
                if (m_tvalid && !m_tready) chk("bp_ready_low", 32'(s_tready), 32'd0);
                hold_prev = m_tvalid && !m_tready;
                prev_data = m_tdata;
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL out_unexpected: got %0h expected no byte", m_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_byte", 32'(m_tdata), 32'(e));
                    end
                    out_cnt++;
                    seen = 1'b1;
                end else if (nogap && seen && exp_q.size() != 0) begin
                    chk("no_gap", 32'(m_tvalid), 32'd1);
                end
            end
        end
    end

    // ---------------- global watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        for (int s = 0; s < N; s++) begin
            src_valid[s] = 1'b0;
            src_data[s]  = 8'h00;
            src_last[s]  = 1'b0;
        end
        clear_pkts();
        #2;
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_m_tdata", 32'(m_tdata), 32'd0);
        chk("rst_s_tready", 32'(s_tready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // single packet from src2
        clear_pkts();
        add_pkt(2, 2, 0);
        pdata[2][0][0] = 8'h11;
        pdata[2][0][1] = 8'h22;
        run_phase("single", 1'b1, 0);

        // all requesters hold one-byte packets back to back
        clear_pkts();
        for (int s = 0; s < N; s++) begin
            add_pkt(s, 1, 0);
            add_pkt(s, 1, 0);
            pdata[s][0][0] = 8'(s);
            pdata[s][1][0] = 8'(s);
        end
        run_phase("round_robin", 1'b1, 0);

        // sink stalls five cycles in the middle of a src1 packet
        clear_pkts();
        add_pkt(1, 6, 0);
        bp_at = 3;
        run_phase("backpressure", 1'b0, 0);

        // src0 pauses mid-packet while src1 waits
        clear_pkts();
        add_pkt(0, 4, 0);
        pgap[0][0][1] = 3;
        add_pkt(1, 2, 0);
        run_phase("grant_hold", 1'b0, 0);

        // lone src3 is re-granted, then src0 wins after the wrap
        clear_pkts();
        for (int p = 0; p < 3; p++) add_pkt(3, 2, 0);
        run_phase("lone", 1'b1, 0);
        clear_pkts();
        add_pkt(0, 1, 0);
        add_pkt(3, 1, 0);
        run_phase("wrap", 1'b1, 0);

        // randomized traffic with random sink stalls and valid gaps
        for (int r = 0; r < 8; r++) begin
            clear_pkts();
            for (int s = 0; s < N; s++) begin
                int k;
                k = $urandom_range(0, 3);
                for (int p = 0; p < k; p++) add_pkt(s, $urandom_range(1, 5), 2);
            end
            run_phase("random", 1'b0, 1);
        end

        // reset in the middle of a src2 packet
        clear_pkts();
        add_pkt(2, 4, 0);
        nogap    = 1'b0;
        seen     = 1'b0;
        rdy_mode = 0;
        out_cnt  = 0;
        exp_q.push_back(8'hA2);
        exp_q.push_back(pdata[2][0][0]);
        start_drivers();
        for (int c = 0; c < 200 && out_cnt < 2; c++) @(negedge clk);
        chk("rst_mid_progress", 32'(out_cnt >= 2), 32'd1);
        chk("rst_mid_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        abort = 1'b1;
        #1;
        chk("rst_mid_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_mid_m_tdata", 32'(m_tdata), 32'd0);
        chk("rst_mid_s_tready", 32'(s_tready), 32'd0);
        chk("rst_mid_busy_low", 32'(busy), 32'd0);
        chk("rst_mid_grant_id", 32'(grant_id), 32'd0);
        for (int c = 0; c < 50 && active_drv != 0; c++) @(negedge clk);
        chk("rst_mid_leftover", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        m_rr  = 0;
        m_gid = 0;
        @(negedge clk);
        rst_n = 1'b1;
        abort = 1'b0;
        @(negedge clk);
        clear_pkts();
        add_pkt(1, 1, 0);
        add_pkt(2, 1, 0);
        run_phase("after_reset", 1'b1, 0);

        repeat (5) @(negedge clk);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
